// File: rtl/vec_mem_initiator_if.sv
// Port bundle for vec_mem_initiator: command, status, in/out streams and
// the 128-bit vector memory controller port.
//   master : seen from the initiator (drives o_*, samples i_*)
//   slave  : seen from the command source / stream partners / memory
// Optional macro DMA_ABORT_EN adds i_abort / o_aborted.
interface vec_mem_initiator_if #(
    parameter int unsigned ADDR_W = 128,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned LEN_W  = 16
);
    // command and status
    logic              i_start;
    logic              i_dir;
    logic [ADDR_W-1:0] i_base_addr;
    logic [LEN_W-1:0]  i_length;
    logic [LEN_W-1:0]  i_stride;
    logic              o_busy;
    logic              o_done;
    // write stream into the initiator
    logic              i_in_valid;
    logic              o_in_ready;
    logic [DATA_W-1:0] i_in_data;
    // read stream out of the initiator
    logic              o_out_valid;
    logic              i_out_ready;
    logic [DATA_W-1:0] o_out_data;
    // memory controller port
    logic              o_mem_we;
    logic              o_mem_vf;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wd;
    logic [DATA_W-1:0] i_mem_rd;
`ifdef DMA_ABORT_EN
    logic              i_abort;
    logic              o_aborted;

    modport master (
        input  i_start, i_dir, i_base_addr, i_length, i_stride,
        input  i_in_valid, i_in_data, i_out_ready, i_mem_rd, i_abort,
        output o_busy, o_done, o_in_ready, o_out_valid, o_out_data,
        output o_mem_we, o_mem_vf, o_mem_addr, o_mem_wd, o_aborted
    );
    modport slave (
        output i_start, i_dir, i_base_addr, i_length, i_stride,
        output i_in_valid, i_in_data, i_out_ready, i_mem_rd, i_abort,
        input  o_busy, o_done, o_in_ready, o_out_valid, o_out_data,
        input  o_mem_we, o_mem_vf, o_mem_addr, o_mem_wd, o_aborted
    );
`else
    modport master (
        input  i_start, i_dir, i_base_addr, i_length, i_stride,
        input  i_in_valid, i_in_data, i_out_ready, i_mem_rd,
        output o_busy, o_done, o_in_ready, o_out_valid, o_out_data,
        output o_mem_we, o_mem_vf, o_mem_addr, o_mem_wd
    );
    modport slave (
        output i_start, i_dir, i_base_addr, i_length, i_stride,
        output i_in_valid, i_in_data, i_out_ready, i_mem_rd,
        input  o_busy, o_done, o_in_ready, o_out_valid, o_out_data,
        input  o_mem_we, o_mem_vf, o_mem_addr, o_mem_wd
    );
`endif
endinterface

// File: rtl/vec_mem_initiator.sv
// Burst initiator for the vector memory controller's 128-bit port.
// Read bursts fetch vectors (4 x 32-bit lanes, lane 0 = bits 31:0) into a
// credit-controlled output FIFO; write bursts turn an input stream into
// vector writes. Optional macro DMA_ABORT_EN adds abort/aborted.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   bus  - vec_mem_initiator_if.master (command, status, streams, memory port)
module vec_mem_initiator #(
    parameter int unsigned ADDR_W     = 128,
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 16
) (
    input logic                 clk,
    input logic                 rst,
    vec_mem_initiator_if.master bus
);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PIPE_L = READ_LAT + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_RUN, S_RD_DRAIN, S_WR_RUN, S_FIN, S_ABORT
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_stride;
    logic [LEN_W-1:0]   r_remaining;
    logic               r_busy;
    logic               r_done;
    logic               r_in_ready;
    logic               r_mem_we;
    logic               r_mem_vf;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wd;
    logic [DATA_W-1:0]  r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic [PIPE_L-1:0]  r_pipe;
`ifdef DMA_ABORT_EN
    logic               r_aborted;
`endif

    logic               w_abort;
    logic [CNT_W-1:0]   w_inflight;
    logic               w_credit_ok;
    logic               w_first_rd;
    logic               w_issue;
    logic               w_issue_any;
    logic               w_push;
    logic               w_pop;
    logic               w_beat;

`ifdef DMA_ABORT_EN
    assign w_abort = bus.i_abort &&
                     (r_state == S_RD_RUN || r_state == S_RD_DRAIN || r_state == S_WR_RUN);
`else
    assign w_abort = 1'b0;
`endif

    // Reads issued but not yet sampled into the FIFO
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < int'(PIPE_L); i++) begin
            w_inflight = w_inflight + CNT_W'(r_pipe[i]);
        end
    end

    assign w_credit_ok = (32'(r_count) + 32'(w_inflight)) < FIFO_DEPTH;
    // The first read goes out on the accept edge so its address is driven
    // in the cycle right after accept; the FIFO is always empty in IDLE.
    assign w_first_rd  = (r_state == S_IDLE) && bus.i_start && !bus.i_dir &&
                         (bus.i_length != '0);
    assign w_issue     = (r_state == S_RD_RUN) && (r_remaining != '0) && w_credit_ok && !w_abort;
    assign w_issue_any = w_issue || w_first_rd;
    assign w_push      = r_pipe[PIPE_L-1] && (r_state != S_ABORT) && !w_abort;
    assign w_pop       = (r_count != '0) && bus.i_out_ready;
    assign w_beat      = (r_state == S_WR_RUN) && r_in_ready && bus.i_in_valid && !w_abort;

    // Read-return pipeline: the top bit marks the edge where mem_rd is valid
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_issue_any;
            for (int i = 1; i < int'(PIPE_L); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Output FIFO; abort flushes it and drops the returning data
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_fifo[i] <= '0;
            end
        end else if (w_abort) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= bus.i_mem_rd;
                r_wptr <= (r_wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Burst control FSM with registered memory-port and status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_stride    <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_vf    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wd    <= '0;
`ifdef DMA_ABORT_EN
            r_aborted   <= 1'b0;
`endif
        end else begin
            r_mem_vf <= 1'b1;
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
`ifdef DMA_ABORT_EN
            r_aborted <= 1'b0;
`endif
            if (w_abort) begin
                r_in_ready <= 1'b0;
                r_state    <= S_ABORT;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.i_start) begin
                            r_stride <= bus.i_stride;
                            if (bus.i_length == '0) begin
                                r_done  <= 1'b1;
                                r_state <= S_FIN;
                            end else if (!bus.i_dir) begin
                                r_mem_addr  <= bus.i_base_addr;
                                r_addr      <= bus.i_base_addr + ADDR_W'(bus.i_stride);
                                r_remaining <= bus.i_length - LEN_W'(1);
                                r_busy      <= 1'b1;
                                r_state     <= (bus.i_length == LEN_W'(1)) ? S_RD_DRAIN : S_RD_RUN;
                            end else begin
                                r_addr      <= bus.i_base_addr;
                                r_remaining <= bus.i_length;
                                r_in_ready  <= 1'b1;
                                r_busy      <= 1'b1;
                                r_state     <= S_WR_RUN;
                            end
                        end
                    end
                    S_RD_RUN: begin
                        if (w_issue) begin
                            r_mem_addr  <= r_addr;
                            r_addr      <= r_addr + ADDR_W'(r_stride);
                            r_remaining <= r_remaining - LEN_W'(1);
                            if (r_remaining == LEN_W'(1)) begin
                                r_state <= S_RD_DRAIN;
                            end
                        end
                    end
                    S_RD_DRAIN: begin
                        // Finish on the edge that leaves the FIFO empty with nothing in flight
                        if (w_inflight == '0 &&
                            (r_count == '0 || (r_count == CNT_W'(1) && w_pop))) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end
                    S_WR_RUN: begin
                        if (w_beat) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_addr;
                            r_mem_wd    <= bus.i_in_data;
                            r_addr      <= r_addr + ADDR_W'(r_stride);
                            r_remaining <= r_remaining - LEN_W'(1);
                            if (r_remaining == LEN_W'(1)) begin
                                r_in_ready <= 1'b0;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                                r_state    <= S_FIN;
                            end
                        end
                    end
                    S_ABORT: begin
                        if (w_inflight == '0) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
`ifdef DMA_ABORT_EN
                            r_aborted <= 1'b1;
`endif
                            r_state <= S_FIN;
                        end
                    end
                    S_FIN: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
    assign bus.o_in_ready  = r_in_ready;
    assign bus.o_out_valid = (r_count != '0);
    assign bus.o_out_data  = r_fifo[r_rptr];
    assign bus.o_mem_we    = r_mem_we;
    assign bus.o_mem_vf    = r_mem_vf;
    assign bus.o_mem_addr  = r_mem_addr;
    assign bus.o_mem_wd    = r_mem_wd;
`ifdef DMA_ABORT_EN
    assign bus.o_aborted   = r_aborted;
`endif
endmodule

// File: tb/tb_vec_mem_initiator.sv
// Self-checking bench for vec_mem_initiator with a READ_LAT=1 memory model.
module tb_vec_mem_initiator;
    localparam int unsigned ADDR_W     = 128;
    localparam int unsigned DATA_W     = 128;
    localparam int unsigned READ_LAT   = 1;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned LEN_W      = 16;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(120000);

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q [$];

    // memory model: synchronous read gives one cycle of read latency
    logic [DATA_W-1:0] mem [64];
    logic [DATA_W-1:0] rd_q;
    logic [ADDR_W-1:0] mem_off;
    logic              pre_we = 1'b0;
    logic [5:0]        pre_idx = '0;
    logic [DATA_W-1:0] pre_data = '0;
    logic [ADDR_W-1:0] prev_addr = '0;
    int addr_chg = 0;
    int we_cnt = 0;

    vec_mem_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    vec_mem_initiator #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT),
        .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign mem_off      = bus.o_mem_addr - BASE;
    assign bus.i_mem_rd = rd_q;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (bus.o_mem_we && mem_off < ADDR_W'(64)) mem[mem_off[5:0]] <= bus.o_mem_wd;
        rd_q <= (mem_off < ADDR_W'(64)) ? mem[mem_off[5:0]] : '0;
    end

    always @(negedge clk) begin
        if (bus.o_mem_addr !== prev_addr) addr_chg <= addr_chg + 1;
        prev_addr <= bus.o_mem_addr;
        if (bus.o_mem_we === 1'b1) we_cnt <= we_cnt + 1;
    end

    function automatic logic [DATA_W-1:0] vec(input int a);
        return {32'(a + 3), 32'(a + 2), 32'(a + 1), 32'(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int i, input logic [DATA_W-1:0] d);
        pre_we = 1'b1; pre_idx = 6'(i); pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    // Returns in the cycle after the accept edge; fields are scrambled after accept
    task automatic start_cmd(input logic d, input logic [ADDR_W-1:0] b,
                             input int len, input int s);
        bus.i_dir = d; bus.i_base_addr = b;
        bus.i_length = LEN_W'(len); bus.i_stride = LEN_W'(s); bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        bus.i_dir = ~d; bus.i_base_addr = '1; bus.i_length = LEN_W'(9); bus.i_stride = LEN_W'(100);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        checks++;
        if (bus.o_mem_we !== 1'b0 || bus.o_mem_vf !== 1'b0 || bus.o_busy !== 1'b0 ||
            bus.o_done !== 1'b0 || bus.o_in_ready !== 1'b0 || bus.o_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: we=%b vf=%b busy=%b done=%b in_ready=%b out_valid=%b, want all 0",
                     bus.o_mem_we, bus.o_mem_vf, bus.o_busy, bus.o_done, bus.o_in_ready, bus.o_out_valid);
        end
        checks++;
        if (bus.o_mem_addr !== '0 || bus.o_mem_wd !== '0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h wd=%h, want 0", bus.o_mem_addr, bus.o_mem_wd);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.o_mem_vf !== 1'b1 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: vf=%b busy=%b, want vf=1 busy=0", bus.o_mem_vf, bus.o_busy);
        end
    endtask

    task automatic test_read();
        logic [DATA_W-1:0] e;
        int pops = 0, last_pop = -1, done_at = -1, we0;
        for (int i = 0; i < 3; i++) preload(4 * i, vec(4 * i + 1));
        for (int i = 0; i < 3; i++) exp_q.push_back(vec(4 * i + 1));
        bus.i_out_ready = 1'b1;
        we0 = we_cnt;
        start_cmd(1'b0, BASE, 3, 4);
        for (int c = 0; c < 30 && done_at < 0; c++) begin
            if (c < 3) begin
                checks++;
                if (bus.o_mem_addr !== BASE + ADDR_W'(4 * c) || bus.o_mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL read_addr c%0d: got %0d we=%b, want %0d we=0",
                             c, bus.o_mem_addr, bus.o_mem_we, BASE + ADDR_W'(4 * c));
                end
            end
            if (bus.o_out_valid === 1'b1) begin
                pops++; last_pop = c;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                checks++;
                if (bus.o_out_data !== e) begin
                    errors++;
                    $display("FAIL read_data #%0d: got %h, want %h", pops, bus.o_out_data, e);
                end
            end
            if (bus.o_done === 1'b1) done_at = c;
            else tick();
        end
        checks++;
        if (done_at < 0 || done_at != last_pop + 1 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL read_done: done at c%0d busy=%b, want c%0d busy=0", done_at, bus.o_busy, last_pop + 1);
        end
        checks++;
        if (pops != 3 || we_cnt != we0) begin
            errors++;
            $display("FAIL read_count: pops=%0d extra_we=%0d, want 3 and 0", pops, we_cnt - we0);
        end
        tick();
    endtask

    task automatic test_write();
        logic [DATA_W-1:0] e;
        int pops = 0, done_at = -1;
        preload(0, '0);
        preload(4, '0);
        bus.i_in_valid = 1'b1; bus.i_in_data = vec(1);
        start_cmd(1'b1, BASE, 2, 4);
        checks++;
        if (bus.o_in_ready !== 1'b1 || bus.o_mem_we !== 1'b0 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL write_c0: in_ready=%b we=%b busy=%b, want 1 0 1", bus.o_in_ready, bus.o_mem_we, bus.o_busy);
        end
        tick();
        checks++;
        if (bus.o_mem_we !== 1'b1 || bus.o_mem_addr !== BASE || bus.o_mem_wd !== vec(1)) begin
            errors++;
            $display("FAIL write_beat0: we=%b addr=%0d wd=%h, want 1 %0d %h", bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wd, BASE, vec(1));
        end
        bus.i_in_data = vec(5);
        tick();
        bus.i_in_valid = 1'b0;
        checks++;
        if (bus.o_mem_we !== 1'b1 || bus.o_mem_addr !== BASE + ADDR_W'(4) || bus.o_mem_wd !== vec(5) ||
            bus.o_done !== 1'b1 || bus.o_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_beat1: we=%b addr=%0d wd=%h done=%b in_ready=%b, want 1 %0d %h 1 0",
                     bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wd, bus.o_done, bus.o_in_ready, BASE + ADDR_W'(4), vec(5));
        end
        tick();
        checks++;
        if (bus.o_mem_we !== 1'b0 || bus.o_done !== 1'b0) begin
            errors++;
            $display("FAIL write_after: we=%b done=%b, want 0 0", bus.o_mem_we, bus.o_done);
        end
        exp_q.push_back(vec(1));
        exp_q.push_back(vec(5));
        bus.i_out_ready = 1'b1;
        start_cmd(1'b0, BASE, 2, 4);
        for (int c = 0; c < 30 && done_at < 0; c++) begin
            if (bus.o_out_valid === 1'b1) begin
                pops++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                checks++;
                if (bus.o_out_data !== e) begin
                    errors++;
                    $display("FAIL readback #%0d: got %h, want %h", pops, bus.o_out_data, e);
                end
            end
            if (bus.o_done === 1'b1) done_at = c;
            else tick();
        end
        checks++;
        if (done_at < 0 || pops != 2) begin
            errors++;
            $display("FAIL readback_end: done_at=%0d pops=%0d, want done and 2 pops", done_at, pops);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] e;
        int pops = 0, done_at = -1, a0;
        for (int i = 0; i < 8; i++) preload(32 + 4 * i, vec(100 + 4 * i));
        for (int i = 0; i < 8; i++) exp_q.push_back(vec(100 + 4 * i));
        bus.i_out_ready = 1'b0;
        a0 = addr_chg;
        start_cmd(1'b0, BASE + ADDR_W'(32), 8, 4);
        for (int c = 0; c < 20; c++) tick();
        checks++;
        if (addr_chg - a0 != 4) begin
            errors++;
            $display("FAIL bp_issued: got %0d reads, want 4", addr_chg - a0);
        end
        checks++;
        if (bus.o_out_valid !== 1'b1 || bus.o_busy !== 1'b1 || bus.o_out_data !== exp_q[0]) begin
            errors++;
            $display("FAIL bp_hold: out_valid=%b busy=%b head=%h, want 1 1 %h", bus.o_out_valid, bus.o_busy, bus.o_out_data, exp_q[0]);
        end
        bus.i_out_ready = 1'b1;
        for (int c = 0; c < 60 && done_at < 0; c++) begin
            if (bus.o_out_valid === 1'b1) begin
                pops++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                checks++;
                if (bus.o_out_data !== e) begin
                    errors++;
                    $display("FAIL bp_data #%0d: got %h, want %h", pops, bus.o_out_data, e);
                end
            end
            if (bus.o_done === 1'b1) done_at = c;
            else tick();
        end
        checks++;
        if (done_at < 0 || pops != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_end: done_at=%0d pops=%0d left=%0d, want done 8 0", done_at, pops, exp_q.size());
        end
        tick();
    endtask

    task automatic test_zero_len_and_busy_start();
        logic [DATA_W-1:0] e;
        int a0, w0, pops = 0, done_at = -1;
        a0 = addr_chg; w0 = we_cnt;
        start_cmd(1'b1, BASE + ADDR_W'(8), 0, 4);
        checks++;
        if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b in_ready=%b, want 1 0 0", bus.o_done, bus.o_busy, bus.o_in_ready);
        end
        tick();
        checks++;
        if (bus.o_done !== 1'b0 || addr_chg != a0 || we_cnt != w0) begin
            errors++;
            $display("FAIL zero_quiet: done=%b addr_chg=%0d we=%0d, want 0 0 0", bus.o_done, addr_chg - a0, we_cnt - w0);
        end
        preload(48, vec(200));
        exp_q.push_back(vec(200));
        bus.i_out_ready = 1'b0;
        start_cmd(1'b0, BASE + ADDR_W'(48), 1, 4);
        bus.i_in_valid = 1'b1; bus.i_in_data = vec(300);
        start_cmd(1'b1, BASE, 3, 4);
        tick(); tick();
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_in_ready !== 1'b0 || bus.o_mem_we !== 1'b0 ||
            bus.o_mem_addr !== BASE + ADDR_W'(48)) begin
            errors++;
            $display("FAIL busy_start: busy=%b in_ready=%b we=%b addr=%0d, want 1 0 0 %0d",
                     bus.o_busy, bus.o_in_ready, bus.o_mem_we, bus.o_mem_addr, BASE + ADDR_W'(48));
        end
        bus.i_in_valid = 1'b0;
        bus.i_out_ready = 1'b1;
        for (int c = 0; c < 20 && done_at < 0; c++) begin
            if (bus.o_out_valid === 1'b1) begin
                pops++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                checks++;
                if (bus.o_out_data !== e) begin
                    errors++;
                    $display("FAIL busy_data: got %h, want %h", bus.o_out_data, e);
                end
            end
            if (bus.o_done === 1'b1) done_at = c;
            else tick();
        end
        checks++;
        if (done_at < 0 || pops != 1) begin
            errors++;
            $display("FAIL busy_end: done_at=%0d pops=%0d, want done and 1", done_at, pops);
        end
        tick();
    endtask

    task automatic test_reset_mid_write();
        int seen_done = 0;
        bus.i_in_valid = 1'b1; bus.i_in_data = vec(40);
        start_cmd(1'b1, BASE + ADDR_W'(16), 3, 4);
        tick();
        checks++;
        if (bus.o_mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rstw_beat: we=%b, want 1", bus.o_mem_we);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.o_mem_we !== 1'b0 || bus.o_mem_vf !== 1'b0 || bus.o_mem_addr !== '0 || bus.o_mem_wd !== '0 ||
            bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_in_ready !== 1'b0 || bus.o_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstw_vals: we=%b vf=%b addr=%h wd=%h busy=%b done=%b in_ready=%b out_valid=%b, want all 0",
                     bus.o_mem_we, bus.o_mem_vf, bus.o_mem_addr, bus.o_mem_wd, bus.o_busy, bus.o_done, bus.o_in_ready, bus.o_out_valid);
        end
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.o_done === 1'b1) seen_done++;
        end
        bus.i_in_valid = 1'b0;
        checks++;
        if (seen_done != 0 || bus.o_mem_vf !== 1'b1) begin
            errors++;
            $display("FAIL rstw_nodone: done pulses=%0d vf=%b, want 0 1", seen_done, bus.o_mem_vf);
        end
        bus.i_in_valid = 1'b1; bus.i_in_data = vec(60);
        start_cmd(1'b1, BASE + ADDR_W'(20), 1, 4);
        tick();
        bus.i_in_valid = 1'b0;
        checks++;
        if (bus.o_mem_we !== 1'b1 || bus.o_mem_addr !== BASE + ADDR_W'(20) || bus.o_mem_wd !== vec(60) || bus.o_done !== 1'b1) begin
            errors++;
            $display("FAIL rstw_new: we=%b addr=%0d wd=%h done=%b, want 1 %0d %h 1",
                     bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wd, bus.o_done, BASE + ADDR_W'(20), vec(60));
        end
        tick();
    endtask

`ifdef DMA_ABORT_EN
    task automatic test_abort();
        logic [ADDR_W-1:0] held;
        int done_at = -1;
        bus.i_out_ready = 1'b0;
        start_cmd(1'b0, BASE, 8, 4);
        tick();
        held = bus.o_mem_addr;
        checks++;
        if (held !== BASE + ADDR_W'(4)) begin
            errors++;
            $display("FAIL abort_c1: addr=%0d, want %0d", held, BASE + ADDR_W'(4));
        end
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        checks++;
        if (bus.o_out_valid !== 1'b0 || bus.o_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_flush: out_valid=%b done=%b, want 0 0", bus.o_out_valid, bus.o_done);
        end
        for (int c = 2; c < 12 && done_at < 0; c++) begin
            if (bus.o_done === 1'b1) begin
                done_at = c;
                checks++;
                if (bus.o_aborted !== 1'b1 || bus.o_out_valid !== 1'b0 || bus.o_mem_addr !== held) begin
                    errors++;
                    $display("FAIL abort_fin: aborted=%b out_valid=%b addr=%0d, want 1 0 %0d",
                             bus.o_aborted, bus.o_out_valid, bus.o_mem_addr, held);
                end
            end else tick();
        end
        checks++;
        if (done_at != 4) begin
            errors++;
            $display("FAIL abort_time: done at c%0d, want c4", done_at);
        end
        tick();
        checks++;
        if (bus.o_aborted !== 1'b0 || bus.o_done !== 1'b0 || bus.o_mem_addr !== held) begin
            errors++;
            $display("FAIL abort_after: aborted=%b done=%b addr=%0d, want 0 0 %0d", bus.o_aborted, bus.o_done, bus.o_mem_addr, held);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_start = 1'b0; bus.i_dir = 1'b0; bus.i_base_addr = '0;
        bus.i_length = '0; bus.i_stride = '0;
        bus.i_in_valid = 1'b0; bus.i_in_data = '0; bus.i_out_ready = 1'b0;
`ifdef DMA_ABORT_EN
        bus.i_abort = 1'b0;
`endif
        test_reset();
        test_read();
        test_write();
        test_backpressure();
        test_zero_len_and_busy_start();
        test_reset_mid_write();
`ifdef DMA_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vec_mem_initiator.md
Name: vec_mem_initiator

Overview:
- Bus initiator for the vector memory controller's 128-bit port (addr/wd/rd, we, vf).
- Takes a burst command (base, count, stride, direction) from the ASIP control path.
- Read bursts: fetches 128-bit vectors (4 x 32-bit pixel lanes) and streams them out through a credit-controlled FIFO.
- Write bursts: accepts an input stream and issues vector writes.

Parameters:
- ADDR_W, 128, memory address width (matches controller addr port)
- DATA_W, 128, vector width (4 lanes x 32 bits, lane 0 = bits 31:0)
- READ_LAT, 1, cycles from address driven to mem_rd valid (0..3)
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >= READ_LAT+1)
- LEN_W, 16, burst count width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  command strobe; accepted only in IDLE
- dir  in  1  0 = read memory to out stream, 1 = in stream to memory write
- base_addr  in  ADDR_W  first vector address
- length  in  LEN_W  vector count
- stride  in  LEN_W  address increment per vector, zero-extended
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse at burst completion
- in_valid / in_ready  in / out  1  write-stream handshake
- in_data  in  DATA_W  write vector
- out_valid / out_ready  out / in  1  read-stream handshake
- out_data  out  DATA_W  read vector (FIFO head)
- mem_we  out  1  write enable to controller
- mem_vf  out  1  vector flag; constant 1 outside reset
- mem_addr  out  ADDR_W  registered address
- mem_wd  out  DATA_W  registered write data
- mem_rd  in  DATA_W  read data from controller

Behaviour:
- Reset (rst=0 at an edge): mem_we=0, mem_vf=0, mem_addr=0, mem_wd=0, busy=0, done=0, in_ready=0, out_valid=0.
  - FIFO, counters and the in-flight pipeline are cleared; state goes to IDLE.
  - Mid-burst reset abandons the burst with no done pulse; in-flight read data is discarded.
- State machine:
  - IDLE: start=1 latches the command. If length=0, go to FIN. Otherwise go to RD_RUN (dir=0) or WR_RUN (dir=1).
  - RD_RUN: issue one read per cycle while remaining>0 and credits>0.
    - Credits = FIFO_DEPTH - fifo_count - inflight.
    - Issuing drives mem_addr = current address with mem_we=0; address += stride.
    - Go to RD_DRAIN when remaining hits 0.
  - RD_DRAIN: wait until inflight=0 and FIFO empty, then go to FIN.
  - WR_RUN: in_ready=1 while remaining>0.
    - Beat on in_valid&in_ready at edge N: mem_we=1, mem_addr=addr, mem_wd=in_data during cycle N+1; mem_we=0 otherwise.
    - After the last beat, go to FIN; FIN is entered in the cycle the last mem_we is high.
  - FIN: done=1 for one cycle, busy=0, then IDLE.
- Read pipeline: mem_rd is sampled into the FIFO READ_LAT cycles after issue. inflight counts issued but not yet sampled reads.
- Out stream:
  - out_valid = FIFO non-empty; out_data = FIFO head; pop on out_valid&out_ready.
  - Push and pop may occur in the same cycle.
  - The FIFO never overflows because of the credit rule.
- start while busy is ignored.
- Command fields are sampled only on accept; later changes have no effect.
- Address arithmetic wraps modulo 2^ADDR_W.
- First read address is driven the cycle after accept.
- mem_vf=1 in every non-reset cycle.

Optional Feature:
- Macro DMA_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit) and output port aborted (1 bit, reset 0).
  - abort=1 in any RD_*/WR_RUN state: stop issuing, force in_ready=0, flush the FIFO, discard inflight returns (wait inflight=0).
  - Then go to FIN with done=1 and aborted=1 for the same single cycle.
  - abort in IDLE is ignored.
- Undefined: neither port exists; behaviour as above.

Test Plan:
- Read: base=120000, length=3, stride=4, dir=0, out_ready=1, memory preloaded {4,3,2,1},{8,7,6,5},{12,11,10,9}.
  - mem_addr=120000/120004/120008 on consecutive cycles, mem_we=0.
  - out_data matches, lanes ordered low=1.
  - done one cycle after last pop.
- Write: base=120000, length=2, dir=1, in_data {4,3,2,1} then {8,7,6,5}, in_valid=1.
  - mem_we high two cycles with addr 120000/120004 and matching wd.
  - Read-back via a subsequent read burst returns the same vectors.
- Backpressure: length=8, FIFO_DEPTH=4, out_ready=0 for 20 cycles.
  - Exactly 4 reads issued, out_valid held, no data lost.
  - Release yields all 8 in order.
- Zero length: start with length=0 gives done on the next cycle and no mem_we or address change. start while busy has no effect.
- Reset mid-write after 1 of 3 beats: all outputs at reset values the next cycle, no done. A new burst then completes normally.
- DMA_ABORT_EN: abort during a read burst with 2 in flight gives done&aborted one cycle after inflight=0, FIFO empty, and no further mem_addr changes.
